itch_ab_arbiter: RTL and testbench

ITCH_AB_ARBITER -- requirements
Module: itch_ab_arbiter

---
 rtl/itch_ab_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_itch_ab_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itch_ab_arbiter.sv
// ITCH A/B feed arbiter.
// Merges two redundant parsed-command streams into a single gap-free, duplicate-free stream
// ordered by the 32-bit message sequence number. Stale and duplicate heads are dropped and
// counted. An isolated out-of-order head is held back for a bounded number of cycles so the
// missing message can still arrive on the other feed. Modes 1 and 2 pass one feed through
// unchanged while the other feed is drained.
module itch_ab_arbiter #(
  parameter int unsigned DATA_W      = 297,
  parameter int unsigned SEQ_LSB     = 48,
  parameter int unsigned GAP_TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic [1:0]        mode,
  input  logic              a_tvalid,
  output logic              a_tready,
  input  logic [DATA_W-1:0] a_tdata,
  input  logic              b_tvalid,
  output logic              b_tready,
  input  logic [DATA_W-1:0] b_tdata,
  output logic              out_tvalid,
  input  logic              out_tready,
  output logic [DATA_W-1:0] out_tdata,
  output logic [31:0]       expected_seq,
  output logic              synced,
  output logic [31:0]       dup_count,
  output logic [31:0]       gap_count
);

  localparam logic [15:0] TimeoutVal = 16'(GAP_TIMEOUT);

  typedef enum logic [1:0] {StSync, StRun, StWait} state_e;

  state_e      state_q;
  logic [15:0] timer_q;
  logic [1:0]  mode_q;

  logic              arb_mode;
  logic              slot_free;
  logic [31:0]       a_seq, b_seq;
  logic signed [31:0] a_diff, b_diff;
  logic              a_stale, a_next, a_ahead;
  logic              b_stale, b_next, b_ahead;

  logic              fwd_a, fwd_b, fwd_any;
  logic              drop_a, drop_b;
  logic              wait_tick;
  logic [31:0]       gap_inc;
  logic [1:0]        dup_inc;
  logic [31:0]       fwd_seq;
  logic [DATA_W-1:0] fwd_data;

  // Classify each head against the next expected sequence number.
  // The signed difference keeps the ordering correct across the 2^32 wrap.
  always_comb begin
    arb_mode  = (mode_q == 2'd0) || (mode_q == 2'd3);
    slot_free = !out_tvalid || out_tready;
    a_seq     = a_tdata[SEQ_LSB +: 32];
    b_seq     = b_tdata[SEQ_LSB +: 32];
    a_diff    = a_seq - expected_seq;
    b_diff    = b_seq - expected_seq;
    a_stale   = a_tvalid && (a_diff < 32'sd0);
    a_next    = a_tvalid && (a_diff == 32'sd0);
    a_ahead   = a_tvalid && (a_diff > 32'sd0);
    b_stale   = b_tvalid && (b_diff < 32'sd0);
    b_next    = b_tvalid && (b_diff == 32'sd0);
    b_ahead   = b_tvalid && (b_diff > 32'sd0);
  end

  // Decide which head is forwarded, which are dropped, and whether the gap timer advances.
  always_comb begin
    fwd_a     = 1'b0;
    fwd_b     = 1'b0;
    drop_a    = 1'b0;
    drop_b    = 1'b0;
    wait_tick = 1'b0;
    gap_inc   = '0;
    if (!arb_mode) begin
      // Pass-through: the unselected feed is drained so it never backs up its parser.
      if (mode_q == 2'd1) begin
        fwd_a  = a_tvalid && slot_free;
        drop_b = b_tvalid;
      end else begin
        fwd_b  = b_tvalid && slot_free;
        drop_a = a_tvalid;
      end
    end else if (state_q == StSync) begin
      // No reference yet: the first head defines the sequence.
      if (slot_free) begin
        fwd_a = a_tvalid;
        fwd_b = !a_tvalid && b_tvalid;
      end
    end else begin
      // Stale heads leave regardless of the output slot.
      drop_a = a_stale;
      drop_b = b_stale;
      if (slot_free) begin
        if (a_next) begin
          fwd_a = 1'b1;
          if (b_next) begin
            drop_b = 1'b1;
          end
        end else if (b_next) begin
          fwd_b = 1'b1;
        end else if (a_ahead && b_ahead) begin
          // Both feeds missed the same message: it is lost, take the lower one now.
          if (b_diff < a_diff) begin
            fwd_b   = 1'b1;
            gap_inc = unsigned'(b_diff);
          end else begin
            fwd_a   = 1'b1;
            gap_inc = unsigned'(a_diff);
            drop_b  = (a_diff == b_diff);
          end
        end else if (a_ahead || b_ahead) begin
          // Only one feed is ahead: give the other feed time to deliver the gap.
          if ((state_q == StWait) && (timer_q == TimeoutVal)) begin
            fwd_a   = a_ahead;
            fwd_b   = b_ahead;
            gap_inc = a_ahead ? unsigned'(a_diff) : unsigned'(b_diff);
          end else begin
            wait_tick = 1'b1;
          end
        end
      end
    end
  end

  // Forward path muxing and drop accounting; drops are only counted while arbitrating.
  always_comb begin
    fwd_any  = fwd_a || fwd_b;
    fwd_seq  = fwd_a ? a_seq : b_seq;
    fwd_data = fwd_a ? a_tdata : b_tdata;
    dup_inc  = {1'b0, arb_mode && drop_a} + {1'b0, arb_mode && drop_b};
    a_tready = nreset && (fwd_a || drop_a);
    b_tready = nreset && (fwd_b || drop_b);
  end

  // Arbitration FSM, output register, sequence tracking and statistics.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q      <= StSync;
      timer_q      <= '0;
      mode_q       <= mode;
      out_tvalid   <= 1'b0;
      out_tdata    <= '0;
      expected_seq <= '0;
      synced       <= 1'b0;
      dup_count    <= '0;
      gap_count    <= '0;
    end else begin
      mode_q    <= mode;
      dup_count <= dup_count + {30'd0, dup_inc};
      gap_count <= gap_count + gap_inc;

      if (fwd_any) begin
        out_tvalid   <= 1'b1;
        out_tdata    <= fwd_data;
        expected_seq <= fwd_seq + 32'd1;
        synced       <= 1'b1;
      end else if (out_tready) begin
        out_tvalid <= 1'b0;
      end

      if (!arb_mode) begin
        // Arbitration resumes in RUN with expected_seq preserved.
        timer_q <= '0;
        if (fwd_any || (state_q == StWait)) begin
          state_q <= StRun;
        end
      end else begin
        unique case (state_q)
          StSync: begin
            if (fwd_any) begin
              state_q <= StRun;
            end
          end
          StRun, StWait: begin
            if (fwd_any) begin
              state_q <= StRun;
              timer_q <= '0;
            end else if (wait_tick) begin
              state_q <= StWait;
              timer_q <= timer_q + 16'd1;
            end
          end
          default: begin
            state_q <= StSync;
            timer_q <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_itch_ab_arbiter.sv
// Bench for itch_ab_arbiter: directed scenarios plus randomized A/B streams, checked by a
// behavioural reference model feeding a scoreboard of expected output words.
module tb_itch_ab_arbiter;

  localparam int unsigned DATA_W  = 297;
  localparam int unsigned SEQ_LSB = 48;
  localparam int unsigned GAP     = 64;

  logic              clock = 1'b0;
  logic              nreset = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic              a_tvalid = 1'b0, b_tvalid = 1'b0;
  logic              a_tready, b_tready;
  logic [DATA_W-1:0] a_tdata = '0, b_tdata = '0;
  logic              out_tvalid;
  logic              out_tready = 1'b1;
  logic [DATA_W-1:0] out_tdata;
  logic [31:0]       expected_seq, dup_count, gap_count;
  logic              synced;

  always #5 clock = ~clock;

  itch_ab_arbiter #(
    .DATA_W      (DATA_W),
    .SEQ_LSB     (SEQ_LSB),
    .GAP_TIMEOUT (GAP)
  ) dut (
    .clock        (clock),
    .nreset       (nreset),
    .mode         (mode),
    .a_tvalid     (a_tvalid),
    .a_tready     (a_tready),
    .a_tdata      (a_tdata),
    .b_tvalid     (b_tvalid),
    .b_tready     (b_tready),
    .b_tdata      (b_tdata),
    .out_tvalid   (out_tvalid),
    .out_tready   (out_tready),
    .out_tdata    (out_tdata),
    .expected_seq (expected_seq),
    .synced       (synced),
    .dup_count    (dup_count),
    .gap_count    (gap_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_data(input string name, input logic [DATA_W-1:0] act,
                            input logic [DATA_W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Both feeds carry bit-identical words for the same sequence number.
  function automatic logic [DATA_W-1:0] mk_word(input logic [31:0] s);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < 9; i++) w[i*32 +: 32] = s * 32'h9E3779B1 + 32'(i);
    w[SEQ_LSB +: 32] = s;
    return w;
  endfunction

  typedef struct {
    int unsigned pre;
    logic [31:0] seq;
  } item_t;

  item_t             qa[$], qb[$];
  logic [DATA_W-1:0] exp_q[$];
  int unsigned       cyc = 0, n_out = 0;
  int unsigned       a_pres_cyc = 0, a_hs_cyc = 0;
  bit                rnd_ready = 1'b0;

  // Reference model state: current output register and sequence bookkeeping.
  bit                m_ovalid = 1'b0;
  logic [DATA_W-1:0] m_odata = '0;
  logic [31:0]       m_exp = '0;
  bit                m_synced = 1'b0;
  int unsigned       m_dup = 0, m_gap = 0, m_wait_cnt = 0;
  logic [1:0]        m_mode = 2'd0;

  // Model: compare registered outputs, predict this cycle's handshakes, then advance.
  always @(negedge clock) begin : model
    logic [31:0] sa, sb;
    int          da, db;
    bit          slot, pa, pb, wt;
    int          take;
    int unsigned dinc, ginc;

    check32("reg_out_tvalid", 32'(out_tvalid), 32'(m_ovalid));
    if (m_ovalid) check_data("reg_out_tdata", out_tdata, m_odata);
    check32("reg_expected_seq", expected_seq, m_exp);
    check32("reg_synced", 32'(synced), 32'(m_synced));
    check32("reg_dup_count", dup_count, m_dup);
    check32("reg_gap_count", gap_count, m_gap);

    sa = a_tdata[SEQ_LSB +: 32];
    sb = b_tdata[SEQ_LSB +: 32];
    da = int'(sa - m_exp);
    db = int'(sb - m_exp);
    slot = !m_ovalid || out_tready;
    pa = 0; pb = 0; take = 0; dinc = 0; ginc = 0; wt = 0;
    if (!nreset) begin
      take = 0;
    end else if (m_mode == 2'd1) begin
      if (a_tvalid && slot) begin pa = 1; take = 1; end
      pb = b_tvalid;
    end else if (m_mode == 2'd2) begin
      if (b_tvalid && slot) begin pb = 1; take = 2; end
      pa = a_tvalid;
    end else if (!m_synced) begin
      if (slot && a_tvalid) begin pa = 1; take = 1; end
      else if (slot && b_tvalid) begin pb = 1; take = 2; end
    end else begin
      if (a_tvalid && da < 0) begin pa = 1; dinc++; end
      if (b_tvalid && db < 0) begin pb = 1; dinc++; end
      if (slot) begin
        if (a_tvalid && da == 0) begin
          pa = 1; take = 1;
          if (b_tvalid && db == 0) begin pb = 1; dinc++; end
        end else if (b_tvalid && db == 0) begin
          pb = 1; take = 2;
        end else if (a_tvalid && da > 0 && b_tvalid && db > 0) begin
          if (db < da) begin pb = 1; take = 2; ginc = unsigned'(db); end
          else begin
            pa = 1; take = 1; ginc = unsigned'(da);
            if (db == da) begin pb = 1; dinc++; end
          end
        end else if ((a_tvalid && da > 0) || (b_tvalid && db > 0)) begin
          if (m_wait_cnt == GAP) begin
            if (a_tvalid && da > 0) begin pa = 1; take = 1; ginc = unsigned'(da); end
            else begin pb = 1; take = 2; ginc = unsigned'(db); end
          end else begin
            wt = 1;
          end
        end
      end
    end
    check32("a_tready", 32'(a_tready), 32'(pa));
    check32("b_tready", 32'(b_tready), 32'(pb));

    if (!nreset) begin
      m_ovalid = 0; m_odata = '0; m_exp = '0; m_synced = 0;
      m_dup = 0; m_gap = 0; m_wait_cnt = 0;
      exp_q.delete();
    end else begin
      if (take != 0) begin
        m_ovalid = 1;
        m_odata  = (take == 1) ? a_tdata : b_tdata;
        m_exp    = ((take == 1) ? sa : sb) + 32'd1;
        m_synced = 1;
        m_wait_cnt = 0;
        exp_q.push_back(m_odata);
      end else if (out_tready) begin
        m_ovalid = 0;
      end
      m_dup += dinc;
      m_gap += ginc;
      if (wt) m_wait_cnt++;
      if (m_mode == 2'd1 || m_mode == 2'd2) m_wait_cnt = 0;
    end
    m_mode = mode;
  end

  // Monitor: every accepted output word must be the next one the model forwarded.
  always @(negedge clock) begin : monitor
    if (nreset && out_tvalid && out_tready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL out_word: got unexpected word %h, required no word", out_tdata);
      end else begin
        check_data("out_word", out_tdata, exp_q.pop_front());
      end
    end
  end

  // One clock: note handshakes, then update feed drivers after the edge.
  task automatic tick();
    bit hs_a, hs_b;
    item_t it;
    @(negedge clock);
    hs_a = a_tvalid && a_tready;
    hs_b = b_tvalid && b_tready;
    if (hs_a) a_hs_cyc = cyc;
    @(posedge clock);
    #1;
    cyc++;
    if (hs_a) a_tvalid = 1'b0;
    if (hs_b) b_tvalid = 1'b0;
    if (!a_tvalid && qa.size() > 0) begin
      if (qa[0].pre > 0) qa[0].pre = qa[0].pre - 1;
      else begin
        it = qa.pop_front();
        a_tvalid = 1'b1; a_tdata = mk_word(it.seq); a_pres_cyc = cyc;
      end
    end
    if (!b_tvalid && qb.size() > 0) begin
      if (qb[0].pre > 0) qb[0].pre = qb[0].pre - 1;
      else begin
        it = qb.pop_front();
        b_tvalid = 1'b1; b_tdata = mk_word(it.seq);
      end
    end
    if (rnd_ready) out_tready = ($urandom_range(3) != 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(qa.size() == 0 && qb.size() == 0 && !a_tvalid && !b_tvalid && !out_tvalid)) begin
      tick();
      n++;
      if (n > budget) begin
        n_tests++;
        n_fail++;
        $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
        qa.delete(); qb.delete();
        a_tvalid = 1'b0; b_tvalid = 1'b0;
        return;
      end
    end
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
  endtask

  task automatic push_a(input logic [31:0] s, input int unsigned pre);
    qa.push_back('{pre: pre, seq: s});
  endtask

  task automatic push_b(input logic [31:0] s, input int unsigned pre);
    qb.push_back('{pre: pre, seq: s});
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned n0;
    logic [31:0] base;

    tick(); tick();
    check32("rst_out_tvalid", 32'(out_tvalid), 32'd0);
    check32("rst_a_tready", 32'(a_tready), 32'd0);
    check32("rst_b_tready", 32'(b_tready), 32'd0);
    check32("rst_expected_seq", expected_seq, 32'd0);
    check32("rst_synced", 32'(synced), 32'd0);
    check32("rst_dup_count", dup_count, 32'd0);
    check32("rst_gap_count", gap_count, 32'd0);
    nreset = 1'b1;

    // B duplicates A one cycle late.
    n0 = n_out;
    for (int i = 0; i < 4; i++) begin
      push_a(32'd100 + 32'(i), 0);
      push_b(32'd100 + 32'(i), (i == 0) ? 1 : 0);
    end
    wait_idle(500);
    check32("dup_words_out", n_out - n0, 32'd4);
    check32("dup_dup_count", dup_count, 32'd4);
    check32("dup_gap_count", gap_count, 32'd0);
    check32("dup_expected", expected_seq, 32'd104);

    // A misses 201, B fills it in.
    do_reset();
    n0 = n_out;
    push_a(32'd200, 0); push_a(32'd202, 0);
    push_b(32'd200, 0); push_b(32'd201, 0); push_b(32'd202, 0);
    wait_idle(500);
    check32("fill_words_out", n_out - n0, 32'd3);
    check32("fill_dup_count", dup_count, 32'd2);
    check32("fill_gap_count", gap_count, 32'd0);
    check32("fill_expected", expected_seq, 32'd203);

    // Real gap on a single feed: forwarded after the timeout.
    do_reset();
    n0 = n_out;
    push_a(32'd300, 0); push_a(32'd305, 2);
    wait_idle(500);
    check32("gap_latency", a_hs_cyc - a_pres_cyc, GAP);
    check32("gap_words_out", n_out - n0, 32'd2);
    check32("gap_gap_count", gap_count, 32'd4);
    check32("gap_expected", expected_seq, 32'd306);

    // Sequence wrap.
    do_reset();
    n0 = n_out;
    push_a(32'hFFFF_FFFE, 0); push_a(32'hFFFF_FFFF, 0); push_a(32'h0, 0);
    wait_idle(500);
    check32("wrap_words_out", n_out - n0, 32'd3);
    check32("wrap_expected", expected_seq, 32'd1);
    check32("wrap_gap_count", gap_count, 32'd0);
    check32("wrap_dup_count", dup_count, 32'd0);

    // Output stall with both feeds streaming.
    do_reset();
    n0 = n_out;
    for (int i = 0; i < 10; i++) begin
      push_a(32'd400 + 32'(i), 0);
      push_b(32'd400 + 32'(i), 0);
    end
    out_tready = 1'b0;
    repeat (10) tick();
    out_tready = 1'b1;
    wait_idle(500);
    check32("stall_words_out", n_out - n0, 32'd10);
    check32("stall_dup_count", dup_count, 32'd10);
    check32("stall_gap_count", gap_count, 32'd0);
    check32("stall_expected", expected_seq, 32'd410);

    // Reset pulse mid-stream, then resync.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      push_a(32'd500 + 32'(i), 0);
      push_b(32'd500 + 32'(i), (i == 0) ? 1 : 0);
    end
    repeat (6) tick();
    do_reset();
    check32("mid_rst_out_tvalid", 32'(out_tvalid), 32'd0);
    check32("mid_rst_expected", expected_seq, 32'd0);
    check32("mid_rst_synced", 32'(synced), 32'd0);
    check32("mid_rst_dup_count", dup_count, 32'd0);
    check32("mid_rst_gap_count", gap_count, 32'd0);
    wait_idle(500);
    check32("resync_synced", 32'(synced), 32'd1);
    check32("resync_expected", expected_seq, 32'd520);
    check32("resync_gap_count", gap_count, 32'd0);

    // Pass-through A, then B, then back to arbitration.
    mode = 2'd1;
    do_reset();
    n0 = n_out;
    for (int i = 0; i < 10; i++) push_a(32'd600 + 32'(i), $urandom_range(2));
    for (int i = 0; i < 5; i++) push_b(32'd700 + 32'(i), 1);
    wait_idle(500);
    check32("pass_a_words_out", n_out - n0, 32'd10);
    check32("pass_a_expected", expected_seq, 32'd610);
    check32("pass_a_dup_count", dup_count, 32'd0);
    check32("pass_a_gap_count", gap_count, 32'd0);
    mode = 2'd2;
    tick();
    n0 = n_out;
    for (int i = 0; i < 5; i++) push_b(32'd800 + 32'(i), $urandom_range(2));
    for (int i = 0; i < 3; i++) push_a(32'd900 + 32'(i), 0);
    wait_idle(500);
    check32("pass_b_words_out", n_out - n0, 32'd5);
    check32("pass_b_expected", expected_seq, 32'd805);
    check32("pass_b_dup_count", dup_count, 32'd0);
    mode = 2'd0;
    tick();
    n0 = n_out;
    for (int i = 0; i < 5; i++) begin
      push_a(32'd805 + 32'(i), 0);
      push_b(32'd805 + 32'(i), 0);
    end
    wait_idle(500);
    check32("rearb_words_out", n_out - n0, 32'd5);
    check32("rearb_expected", expected_seq, 32'd810);
    check32("rearb_dup_count", dup_count, 32'd5);
    check32("rearb_gap_count", gap_count, 32'd0);

    // Randomized lossy redundant feeds with output backpressure.
    for (int r = 0; r < 2; r++) begin
      rnd_ready = 1'b1;
      do_reset();
      base = (r == 0) ? 32'hFFFF_FF80 : $urandom;
      for (int k = 0; k < 300; k++) begin
        if ($urandom_range(99) < 88) push_a(base + 32'(k), $urandom_range(2));
        if ($urandom_range(99) < 88) push_b(base + 32'(k), $urandom_range(3));
      end
      wait_idle(20000);
      rnd_ready = 1'b0;
      out_tready = 1'b1;
      tick();
    end

    check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
